// File: rtl/pc_sequencer.sv
// pc_sequencer
//   Owns the program counter and sequences instruction fetch from a
//   word-addressed instruction memory over a req/ack handshake.
//   The PC advances by one per completed fetch, or is redirected by
//   jump/branch. Supports downstream stall and halt/resume.
//
// Ports
//   clk, rst_n       system clock (rising edge), async active-low reset
//   imem_req/addr    outstanding fetch request and its word address (= pc)
//   imem_ack         memory completes the current fetch this cycle
//   stall            downstream cannot accept instructions
//   branch_taken/    branch redirect request and destination
//   branch_target
//   jump/jump_target jump redirect (wins over a simultaneous branch)
//   halt, resume     stop fetching / restart fetching from HALT
//   pc               current PC register
//   fetch_pc/valid   one-cycle pulse announcing the instruction at fetch_pc
//   state            IDLE=0, FETCH=1, STALL=2, HALT=3
//   fetch_count      number of delivered (non-squashed) fetches, wraps
module pc_sequencer #(
  parameter int unsigned   PC_WIDTH = 32,
  parameter logic [PC_WIDTH-1:0] RESET_PC = '0
) (
  input  logic                clk,
  input  logic                rst_n,
  output logic                imem_req,
  output logic [PC_WIDTH-1:0] imem_addr,
  input  logic                imem_ack,
  input  logic                stall,
  input  logic                branch_taken,
  input  logic [PC_WIDTH-1:0] branch_target,
  input  logic                jump,
  input  logic [PC_WIDTH-1:0] jump_target,
  input  logic                halt,
  input  logic                resume,
  output logic [PC_WIDTH-1:0] pc,
  output logic [PC_WIDTH-1:0] fetch_pc,
  output logic                fetch_valid,
  output logic [1:0]          state,
  output logic [31:0]         fetch_count
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    FETCH = 2'd1,
    STALL = 2'd2,
    HALT  = 2'd3
  } state_e;

  state_e              state_q, state_d;
  logic [PC_WIDTH-1:0] pc_q, pc_d;
  logic                pend_q, pend_d;
  logic [PC_WIDTH-1:0] pend_target_q, pend_target_d;
  logic [PC_WIDTH-1:0] fetch_pc_q, fetch_pc_d;
  logic                fetch_valid_q, fetch_valid_d;
  logic [31:0]         fetch_count_q, fetch_count_d;

  logic                redir;
  logic [PC_WIDTH-1:0] redir_target;

  // Jump outranks branch when both are asserted in the same cycle.
  assign redir        = jump | branch_taken;
  assign redir_target = jump ? jump_target : branch_target;

  assign imem_req    = (state_q == FETCH);
  assign imem_addr   = pc_q;
  assign pc          = pc_q;
  assign fetch_pc    = fetch_pc_q;
  assign fetch_valid = fetch_valid_q;
  assign state       = state_q;
  assign fetch_count = fetch_count_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q       <= IDLE;
      pc_q          <= RESET_PC;
      pend_q        <= 1'b0;
      pend_target_q <= '0;
      fetch_pc_q    <= '0;
      fetch_valid_q <= 1'b0;
      fetch_count_q <= '0;
    end else begin
      state_q       <= state_d;
      pc_q          <= pc_d;
      pend_q        <= pend_d;
      pend_target_q <= pend_target_d;
      fetch_pc_q    <= fetch_pc_d;
      fetch_valid_q <= fetch_valid_d;
      fetch_count_q <= fetch_count_d;
    end
  end

  always_comb begin
    state_d       = state_q;
    pc_d          = pc_q;
    pend_d        = pend_q;
    pend_target_d = pend_target_q;
    fetch_pc_d    = fetch_pc_q;
    fetch_valid_d = 1'b0;
    fetch_count_d = fetch_count_q;

    unique case (state_q)
      IDLE: begin
        state_d = FETCH;
      end

      FETCH: begin
        if (!imem_ack) begin
          // The request in flight must finish at its own address, so a
          // redirect arriving now is parked until the ack; newest wins.
          if (redir) begin
            pend_d        = 1'b1;
            pend_target_d = redir_target;
          end
        end else begin
          if (pend_q || redir) begin
            // Fetched word is on the wrong path: drop it and redirect.
            pc_d   = redir ? redir_target : pend_target_q;
            pend_d = 1'b0;
          end else begin
            fetch_valid_d = 1'b1;
            fetch_pc_d    = pc_q;
            fetch_count_d = fetch_count_q + 32'd1;
            pc_d          = pc_q + PC_WIDTH'(1);
          end
          // halt/stall only take effect once the request has completed.
          if (halt) begin
            state_d = HALT;
          end else if (stall) begin
            state_d = STALL;
          end else begin
            state_d = FETCH;
          end
        end
      end

      STALL: begin
        if (redir) begin
          pc_d = redir_target;
        end
        if (halt) begin
          state_d = HALT;
        end else if (!stall) begin
          state_d = FETCH;
        end
      end

      HALT: begin
        if (redir) begin
          pc_d = redir_target;
        end
        if (resume && !halt) begin
          state_d = FETCH;
        end
      end

      default: begin
        state_d = IDLE;
      end
    endcase
  end

endmodule

// File: tb/tb_pc_sequencer.sv
// tb_pc_sequencer
//   Self-checking bench for pc_sequencer (PC_WIDTH=32, RESET_PC=0x100).
//   Expected fetch addresses are queued when an ack is driven and are
//   matched against fetch_pc whenever fetch_valid pulses.
module tb_pc_sequencer;

  localparam logic [31:0] RESET_PC = 32'h0000_0100;

  logic        clk;
  logic        rst_n;
  logic        imem_req;
  logic [31:0] imem_addr;
  logic        imem_ack;
  logic        stall;
  logic        branch_taken;
  logic [31:0] branch_target;
  logic        jump;
  logic [31:0] jump_target;
  logic        halt;
  logic        resume;
  logic [31:0] pc;
  logic [31:0] fetch_pc;
  logic        fetch_valid;
  logic [1:0]  state;
  logic [31:0] fetch_count;

  int checks;
  int failures;
  logic [31:0] expQueue[$];

  pc_sequencer #(
    .PC_WIDTH (32),
    .RESET_PC (RESET_PC)
  ) dut (
    .clk           (clk),
    .rst_n         (rst_n),
    .imem_req      (imem_req),
    .imem_addr     (imem_addr),
    .imem_ack      (imem_ack),
    .stall         (stall),
    .branch_taken  (branch_taken),
    .branch_target (branch_target),
    .jump          (jump),
    .jump_target   (jump_target),
    .halt          (halt),
    .resume        (resume),
    .pc            (pc),
    .fetch_pc      (fetch_pc),
    .fetch_valid   (fetch_valid),
    .state         (state),
    .fetch_count   (fetch_count)
  );

  // Free-running 10 ns clock.
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // Scoreboard consumer: each fetch_valid pulse must match the oldest
  // expected address; a pulse with nothing expected is itself an error.
  always @(negedge clk) begin
    if (rst_n && fetch_valid) begin
      checks++;
      if (expQueue.size() == 0) begin
        failures++;
        $display("[TB] FAIL unexpected_fetch_valid: got fetch_pc %h, required no fetch_valid", fetch_pc);
      end else begin
        logic [31:0] expPc;
        expPc = expQueue.pop_front();
        if (fetch_pc !== expPc) begin
          failures++;
          $display("[TB] FAIL fetch_pc: got %h, required %h", fetch_pc, expPc);
        end
      end
    end
  end

  // Safety net so the run can never hang.
  initial begin
    #200000;
    $display("[TB] FAIL watchdog: simulation time limit reached");
    $fatal(1, "[TB] watchdog expired");
  end

  // Advance one clock and sample shortly after the active edge.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    checks++;
    if (pc !== RESET_PC) begin
      failures++;
      $display("[TB] FAIL reset_pc: got %h, required %h", pc, RESET_PC);
    end
    checks++;
    if (state !== 2'd0 || imem_req !== 1'b0) begin
      failures++;
      $display("[TB] FAIL reset_state: got state %0d req %b, required state 0 req 0", state, imem_req);
    end
    checks++;
    if (fetch_valid !== 1'b0 || fetch_count !== 32'd0 || fetch_pc !== 32'd0) begin
      failures++;
      $display("[TB] FAIL reset_fetch: got valid %b count %0d fetch_pc %h, required 0 0 0",
               fetch_valid, fetch_count, fetch_pc);
    end
  endtask

  // Back-to-back acks from the reset PC; the third ack comes with stall.
  task automatic test_back_to_back();
    step();
    checks++;
    if (state !== 2'd1 || imem_req !== 1'b1) begin
      failures++;
      $display("[TB] FAIL idle_to_fetch: got state %0d req %b, required state 1 req 1", state, imem_req);
    end
    for (int i = 0; i < 3; i++) begin
      checks++;
      if (imem_addr !== RESET_PC + 32'(i)) begin
        failures++;
        $display("[TB] FAIL seq_addr_%0d: got %h, required %h", i, imem_addr, RESET_PC + 32'(i));
      end
      imem_ack = 1'b1;
      stall    = (i == 2);
      expQueue.push_back(RESET_PC + 32'(i));
      step();
    end
    imem_ack = 1'b0;
    checks++;
    if (fetch_count !== 32'd3 || state !== 2'd2 || imem_req !== 1'b0 || pc !== 32'h103) begin
      failures++;
      $display("[TB] FAIL seq_end: got count %0d state %0d req %b pc %h, required 3 2 0 00000103",
               fetch_count, state, imem_req, pc);
    end
    step();
    checks++;
    if (state !== 2'd2 || imem_req !== 1'b0) begin
      failures++;
      $display("[TB] FAIL stall_hold: got state %0d req %b, required 2 0", state, imem_req);
    end
  endtask

  // Redirects parked while a fetch is outstanding; the late jump wins.
  task automatic test_redirect_pending();
    branch_taken  = 1'b1;
    branch_target = 32'h20;
    step();
    checks++;
    if (pc !== 32'h20 || state !== 2'd2) begin
      failures++;
      $display("[TB] FAIL stall_redirect: got pc %h state %0d, required 00000020 2", pc, state);
    end
    branch_taken = 1'b0;
    stall        = 1'b0;
    step();
    checks++;
    if (state !== 2'd1 || imem_addr !== 32'h20) begin
      failures++;
      $display("[TB] FAIL stall_exit: got state %0d addr %h, required 1 00000020", state, imem_addr);
    end
    branch_taken  = 1'b1;
    branch_target = 32'h80;
    step();
    branch_taken = 1'b0;
    jump         = 1'b1;
    jump_target  = 32'h90;
    step();
    checks++;
    if (imem_req !== 1'b1 || imem_addr !== 32'h20) begin
      failures++;
      $display("[TB] FAIL req_held: got req %b addr %h, required 1 00000020", imem_req, imem_addr);
    end
    jump     = 1'b0;
    imem_ack = 1'b1;
    step();
    imem_ack = 1'b0;
    checks++;
    if (imem_addr !== 32'h90 || fetch_valid !== 1'b0 || fetch_count !== 32'd3 || state !== 2'd1) begin
      failures++;
      $display("[TB] FAIL pending_squash: got addr %h valid %b count %0d state %0d, required 00000090 0 3 1",
               imem_addr, fetch_valid, fetch_count, state);
    end
  endtask

  // Jump and branch with the ack in one cycle: jump wins, fetch dropped.
  task automatic test_same_cycle_redirect();
    imem_ack      = 1'b1;
    jump          = 1'b1;
    jump_target   = 32'h40;
    branch_taken  = 1'b1;
    branch_target = 32'h50;
    step();
    jump         = 1'b0;
    branch_taken = 1'b0;
    checks++;
    if (pc !== 32'h40 || fetch_valid !== 1'b0 || fetch_count !== 32'd3) begin
      failures++;
      $display("[TB] FAIL jump_priority: got pc %h valid %b count %0d, required 00000040 0 3",
               pc, fetch_valid, fetch_count);
    end
    halt = 1'b1;
    expQueue.push_back(32'h40);
    step();
    imem_ack = 1'b0;
    checks++;
    if (state !== 2'd3 || pc !== 32'h41 || fetch_count !== 32'd4 || imem_req !== 1'b0) begin
      failures++;
      $display("[TB] FAIL ack_to_halt: got state %0d pc %h count %0d req %b, required 3 00000041 4 0",
               state, pc, fetch_count, imem_req);
    end
  endtask

  // halt dominates resume; stray acks ignored; resume alone restarts.
  task automatic test_halt_resume();
    resume   = 1'b1;
    imem_ack = 1'b1;
    step();
    imem_ack = 1'b0;
    checks++;
    if (state !== 2'd3 || fetch_count !== 32'd4 || pc !== 32'h41) begin
      failures++;
      $display("[TB] FAIL halt_dominates: got state %0d count %0d pc %h, required 3 4 00000041",
               state, fetch_count, pc);
    end
    halt        = 1'b0;
    resume      = 1'b0;
    jump        = 1'b1;
    jump_target = 32'hFFFF_FFFF;
    step();
    jump = 1'b0;
    checks++;
    if (state !== 2'd3 || pc !== 32'hFFFF_FFFF) begin
      failures++;
      $display("[TB] FAIL halt_redirect: got state %0d pc %h, required 3 ffffffff", state, pc);
    end
    resume = 1'b1;
    step();
    resume = 1'b0;
    checks++;
    if (state !== 2'd1 || imem_addr !== 32'hFFFF_FFFF) begin
      failures++;
      $display("[TB] FAIL resume: got state %0d addr %h, required 1 ffffffff", state, imem_addr);
    end
  endtask

  // Stall waits for the ack; the completing ack wraps the PC to zero.
  task automatic test_wrap_stall();
    stall = 1'b1;
    step();
    checks++;
    if (state !== 2'd1 || imem_req !== 1'b1 || imem_addr !== 32'hFFFF_FFFF) begin
      failures++;
      $display("[TB] FAIL stall_waits_ack: got state %0d req %b addr %h, required 1 1 ffffffff",
               state, imem_req, imem_addr);
    end
    imem_ack = 1'b1;
    expQueue.push_back(32'hFFFF_FFFF);
    step();
    imem_ack = 1'b0;
    checks++;
    if (state !== 2'd2 || pc !== 32'h0 || fetch_count !== 32'd5 || imem_req !== 1'b0) begin
      failures++;
      $display("[TB] FAIL wrap: got state %0d pc %h count %0d req %b, required 2 00000000 5 0",
               state, pc, fetch_count, imem_req);
    end
    stall = 1'b0;
    step();
    checks++;
    if (state !== 2'd1 || imem_addr !== 32'h0) begin
      failures++;
      $display("[TB] FAIL wrap_refetch: got state %0d addr %h, required 1 00000000", state, imem_addr);
    end
  endtask

  // Reset in the middle of an outstanding fetch acts without a clock edge.
  task automatic test_async_reset();
    #2;
    rst_n    = 1'b0;
    imem_ack = 1'b1;
    #1;
    checks++;
    if (imem_req !== 1'b0 || state !== 2'd0 || pc !== RESET_PC) begin
      failures++;
      $display("[TB] FAIL async_reset: got req %b state %0d pc %h, required 0 0 %h",
               imem_req, state, pc, RESET_PC);
    end
    step();
    checks++;
    if (state !== 2'd0 || fetch_count !== 32'd0 || fetch_valid !== 1'b0) begin
      failures++;
      $display("[TB] FAIL ack_in_reset: got state %0d count %0d valid %b, required 0 0 0",
               state, fetch_count, fetch_valid);
    end
    @(negedge clk);
    imem_ack = 1'b0;
    rst_n    = 1'b1;
    step();
    checks++;
    if (state !== 2'd1 || imem_addr !== RESET_PC) begin
      failures++;
      $display("[TB] FAIL post_reset_fetch: got state %0d addr %h, required 1 %h", state, imem_addr, RESET_PC);
    end
  endtask

  initial begin
    checks        = 0;
    failures      = 0;
    rst_n         = 1'b0;
    imem_ack      = 1'b0;
    stall         = 1'b0;
    branch_taken  = 1'b0;
    branch_target = '0;
    jump          = 1'b0;
    jump_target   = '0;
    halt          = 1'b0;
    resume        = 1'b0;
    repeat (2) @(negedge clk);
    rst_n = 1'b1;

    test_reset();
    test_back_to_back();
    test_redirect_pending();
    test_same_cycle_redirect();
    test_halt_resume();
    test_wrap_stall();
    test_async_reset();

    @(negedge clk);
    checks++;
    if (expQueue.size() != 0) begin
      failures++;
      $display("[TB] FAIL scoreboard_drain: got %0d outstanding fetches, required 0", expQueue.size());
    end

    $display("End of test - %0d assertions evaluated, %0d failures", checks, failures);
    $finish;
  end

endmodule
